// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : regfile_arb_pkg
// Brief  : Shared constants and types for the register-file write arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package regfile_arb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_WB     = 2'd1,
        SRC_FIFO   = 2'd2,
        SRC_BYPASS = 2'd3
    } grant_src_t;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } ret_entry_t;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : regfile_wb_arbiter_if
// Brief  : Pipeline/memory-side bundle for the register-file write arbiter.
// Rev    : 1.0  initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
    parameter int DATA_W     = regfile_arb_pkg::DATA_W,
    parameter int ADDR_W     = regfile_arb_pkg::ADDR_W,
    parameter int FIFO_DEPTH = 2
);
    logic              wb_en;
    logic [ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0] wb_result;
    logic              mem_ret_valid;
    logic              mem_ret_ready;
    logic [ADDR_W-1:0] mem_ret_dest;
    logic [DATA_W-1:0] mem_ret_data;
    logic              mem_issue_valid;
    logic [ADDR_W-1:0] mem_issue_dest;
    logic              mem_issue_ready;
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
    logic              use_src1;
    logic              use_src2;
    logic [ADDR_W-1:0] id_dest;
    logic              use_dest;
    logic              hazard;
    logic              rf_wb_en;
    logic [ADDR_W-1:0] rf_dest;
    logic [DATA_W-1:0] rf_result;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    modport master (
        output wb_en, wb_dest, wb_result,
        output mem_ret_valid, mem_ret_dest, mem_ret_data,
        output mem_issue_valid, mem_issue_dest,
        output src1, src2, use_src1, use_src2, id_dest, use_dest,
        input  mem_ret_ready, mem_issue_ready, hazard,
        input  rf_wb_en, rf_dest, rf_result, fifo_count
    );

    modport slave (
        input  wb_en, wb_dest, wb_result,
        input  mem_ret_valid, mem_ret_dest, mem_ret_data,
        input  mem_issue_valid, mem_issue_dest,
        input  src1, src2, use_src1, use_src2, id_dest, use_dest,
        output mem_ret_ready, mem_issue_ready, hazard,
        output rf_wb_en, rf_dest, rf_result, fifo_count
    );

endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module : wb_ret_fifo
// Brief  : In-order synchronous FIFO with full/empty/count, async reset.
// Rev    : 1.0  initial release
// ============================================================================
module wb_ret_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 2
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_push,
    input  wire logic [WIDTH-1:0]         i_wdata,
    input  wire logic                     i_pop,
    output logic      [WIDTH-1:0]         o_rdata,
    output logic                          o_full,
    output logic                          o_empty,
    output logic      [$clog2(DEPTH):0]   o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign o_full    = (r_count == (c_PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module : regfile_wb_arbiter
// Brief  : Shares the register-file write port between WB and load returns,
//          with a per-register outstanding-load scoreboard for ID hazards.
// Rev    : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DATA_W     = regfile_arb_pkg::DATA_W,
    parameter int ADDR_W     = regfile_arb_pkg::ADDR_W,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    regfile_wb_arbiter_if.slave bus
);

    import regfile_arb_pkg::*;

    localparam int               c_NUM_REGS = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    grant_src_t         w_src;
    ret_entry_t         w_head;
    ret_entry_t         w_enq_entry;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_commit;
    logic [ADDR_W-1:0]  w_commit_dest;
    logic [CNT_W-1:0]   r_cnt     [c_NUM_REGS];
    logic [CNT_W-1:0]   w_cnt_nxt [c_NUM_REGS];

    // Reset forces the grant off so the register file sees no write while rst is high.
    always_comb begin
        w_src = SRC_NONE;
        if (rst)                     w_src = SRC_NONE;
        else if (bus.wb_en)          w_src = SRC_WB;
        else if (!w_empty)           w_src = SRC_FIFO;
        else if (bus.mem_ret_valid)  w_src = SRC_BYPASS;
    end

    always_comb begin
        bus.rf_wb_en  = 1'b0;
        bus.rf_dest   = '0;
        bus.rf_result = '0;
        case (w_src)
            SRC_WB: begin
                bus.rf_wb_en  = 1'b1;
                bus.rf_dest   = bus.wb_dest;
                bus.rf_result = bus.wb_result;
            end
            SRC_FIFO: begin
                bus.rf_wb_en  = 1'b1;
                bus.rf_dest   = w_head.dest;
                bus.rf_result = w_head.data;
            end
            SRC_BYPASS: begin
                bus.rf_wb_en  = 1'b1;
                bus.rf_dest   = bus.mem_ret_dest;
                bus.rf_result = bus.mem_ret_data;
            end
            default: ;
        endcase
    end

    assign bus.mem_ret_ready = ~w_full;
    assign w_push            = bus.mem_ret_valid & ~w_full & (w_src != SRC_BYPASS);
    assign w_pop             = (w_src == SRC_FIFO);
    assign w_enq_entry.dest  = bus.mem_ret_dest;
    assign w_enq_entry.data  = bus.mem_ret_data;
    assign w_commit          = (w_src == SRC_FIFO) | (w_src == SRC_BYPASS);
    assign w_commit_dest     = (w_src == SRC_FIFO) ? w_head.dest : bus.mem_ret_dest;

    wb_ret_fifo #(
        .WIDTH ($bits(ret_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_ret_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_enq_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (bus.fifo_count)
    );

    // Issue and commit to the same register cancel; saturation and underflow hold.
    for (genvar g = 0; g < c_NUM_REGS; g++) begin : g_cnt
        logic w_inc;
        logic w_dec;
        assign w_inc = bus.mem_issue_valid && (bus.mem_issue_dest == ADDR_W'(g));
        assign w_dec = w_commit && (w_commit_dest == ADDR_W'(g));
        assign w_cnt_nxt[g] =
            (w_inc && !w_dec && r_cnt[g] != c_CNT_MAX) ? r_cnt[g] + CNT_W'(1) :
            (w_dec && !w_inc && r_cnt[g] != '0)        ? r_cnt[g] - CNT_W'(1) :
                                                         r_cnt[g];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '{default: '0};
        else     r_cnt <= w_cnt_nxt;
    end

    assign bus.mem_issue_ready = (r_cnt[bus.mem_issue_dest] != c_CNT_MAX);
    assign bus.hazard = (bus.use_src1 && r_cnt[bus.src1]    != '0) |
                        (bus.use_src2 && r_cnt[bus.src2]    != '0) |
                        (bus.use_dest && r_cnt[bus.id_dest] != '0);

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between the pipeline WB stage and a late memory-return path (load data from SRAM/cache).
- The memory-return path is buffered in a small FIFO.
- A per-register scoreboard tracks outstanding loads and raises a hazard for the ID stage.
- Sits between WB/MEM stages and the register file write inputs (writeBackEn, Dest_wb, Result_WB).

Parameters:
- DATA_W, 32, register/data width
- ADDR_W, 4, register index width (16 registers)
- FIFO_DEPTH, 2, memory-return buffer entries (power of two)
- CNT_W, 2, per-register outstanding-load counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wb_en  in  1  WB stage write request (highest priority, never stalled)
- wb_dest  in  ADDR_W  WB destination register
- wb_result  in  DATA_W  WB data
- mem_ret_valid  in  1  memory-return write request
- mem_ret_ready  out  1  arbiter accepts memory return this cycle
- mem_ret_dest  in  ADDR_W  memory-return destination
- mem_ret_data  in  DATA_W  memory-return data
- mem_issue_valid  in  1  a load leaves EXE toward memory
- mem_issue_dest  in  ADDR_W  destination of the issued load
- mem_issue_ready  out  1  counter of mem_issue_dest not saturated
- src1, src2  in  ADDR_W  ID-stage source registers
- use_src1, use_src2  in  1  source operands are live
- id_dest  in  ADDR_W  ID-stage destination register
- use_dest  in  1  ID instruction writes a register
- hazard  out  1  ID must freeze
- rf_wb_en  out  1  to register file writeBackEn
- rf_dest  out  ADDR_W  to register file Dest_wb
- rf_result  out  DATA_W  to register file Result_WB
- fifo_count  out  $clog2(FIFO_DEPTH)+1  buffered entries (debug)

Behaviour:
- Reset (async, rst=1):
  - FIFO empty; all counters 0; fifo_count=0.
  - rf_wb_en=0, rf_dest=0, rf_result=0.
  - mem_ret_ready=1 (combinational from empty FIFO).
  - hazard=0.
- Write-port selection (combinational each cycle, priority order):
  1. wb_en=1: grant WB; rf_dest/rf_result=wb_dest/wb_result.
  2. FIFO non-empty: grant FIFO head; dequeue at clk edge.
  3. FIFO empty and mem_ret_valid=1: bypass, grant memory return directly; no enqueue.
  4. Else: rf_wb_en=0; rf_dest and rf_result are driven 0.
- mem_ret_ready = !full, where full is the registered FIFO state. Simultaneous dequeue does not free a slot in the same cycle.
- Enqueue occurs when mem_ret_valid & mem_ret_ready and the return is not bypassed. The FIFO is strictly in order.
- Enqueue and dequeue may occur in the same cycle; count is unchanged.
- Scoreboard counter cnt[r]:
  - +1 on mem_issue_valid for r.
  - -1 when a memory-sourced write to r is granted (FIFO or bypass).
  - Issue and commit to the same r in the same cycle: net 0.
  - Buffered (not yet granted) entries keep the count.
- mem_issue_ready = (cnt[mem_issue_dest] != all-ones). Issue while not ready is a protocol violation; the counter holds, it does not wrap.
- Commit with cnt=0 is a protocol violation; the counter holds at 0.
- hazard = (use_src1 & cnt[src1]!=0) | (use_src2 & cnt[src2]!=0) | (use_dest & cnt[id_dest]!=0).
  - The dest term prevents WAW between WB and an outstanding load. WB and the memory return therefore never target the same register concurrently; the bench asserts this.
- Latency:
  - WB: 0 cycles, combinational pass-through.
  - Memory return: 0 cycles on bypass; otherwise granted on the first cycle with wb_en=0 after all older entries drain.
  - Counter update visible on hazard the cycle after the edge.
- Reset mid-operation: all buffered returns and counters are discarded.

Decomposition:
- Package regfile_arb_pkg holds:
  - DATA_W and ADDR_W constants;
  - grant-source enum {SRC_NONE, SRC_WB, SRC_FIFO, SRC_BYPASS};
  - FIFO entry struct {dest, data}.
- One sub-module: wb_ret_fifo, a parameterised synchronous FIFO with full/empty/count and async active-high reset.
- Scoreboard and grant mux stay in the top.

Test Plan:
- Reset then idle -> rf_wb_en=0, mem_ret_ready=1, hazard=0, fifo_count=0.
- wb_en=1, wb_dest=5, wb_result=6, FIFO empty, no mem_ret -> same-cycle rf_wb_en=1, rf_dest=5, rf_result=6; register 5 reads 6 after the edge.
- Issue load to r6, then mem_ret_valid with dest=6, data=7 while wb_en=0 -> bypass write in that cycle; cnt[6] 1->0; hazard for src1=6 is 1 before the commit and 0 the cycle after.
- Issue loads to r2 and r3; hold wb_en=1 for 4 cycles while returns (2,0xA) and (3,0xB) arrive:
  - both are enqueued; fifo_count=2; mem_ret_ready=0;
  - a third return stalls;
  - after wb_en drops, writes commit as r2=0xA then r3=0xB on consecutive cycles.
- Issue three loads to r4 -> mem_issue_ready drops to 0 (cnt=3); issue plus commit on r4 in the same cycle keeps cnt=3.
- Assert rst mid-stream with 2 buffered entries -> outputs zero immediately (async); after release the entries are never written and hazard=0.
